// File: rtl/lfsr_noise_gen.sv
// XNOR Fibonacci LFSR noise source for the DDS noise waveform, with runtime seed load,
// an update-rate divider, an all-ones lock-up guard, a wrap marker and optional signed output.
module lfsr_noise_gen #(
    parameter int unsigned    N      = 14,
    parameter int unsigned    M      = 12,
    parameter logic [N-1:0]   TAPS   = N'(14'h3802),
    parameter logic [N-1:0]   SEED   = '0,
    parameter int unsigned    DIV_W  = 8,
    parameter bit             SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic             seed_load,
    input  logic [N-1:0]     seed,
    output logic [M-1:0]     noise,
    output logic             step,
    output logic             wrap
);

    localparam logic [N-1:0] ONES      = '1;
    localparam logic [M-1:0] SIGN_MASK = SIGNED ? {1'b1, {(M-1){1'b0}}} : '0;

    logic [N-1:0]     shift_q, shift_d;
    logic [N-1:0]     seed_q, seed_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;
    logic             fb;
    logic [N-1:0]     adv;
    logic [N-1:0]     seed_eff;

    // Next-state: seed_load outranks the divider; en low freezes everything.
    always_comb begin
        shift_d  = shift_q;
        seed_d   = seed_q;
        cnt_d    = cnt_q;
        step_d   = 1'b0;
        wrap_d   = 1'b0;
        fb       = ~^(shift_q & TAPS);
        adv      = {shift_q[N-2:0], fb};
        seed_eff = (seed == ONES) ? SEED : seed;

        if (seed_load) begin
            shift_d = seed_eff;
            seed_d  = seed_eff;
            cnt_d   = '0;
        end else if (en) begin
            if (cnt_q >= div) begin
                // All-ones is the XNOR fixed point; escape by reloading the seed.
                shift_d = (shift_q == ONES) ? seed_q : adv;
                step_d  = 1'b1;
                wrap_d  = (shift_d == seed_q);
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= SEED;
            seed_q  <= SEED;
            cnt_q   <= '0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            seed_q  <= seed_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
        end
    end

    assign noise = shift_q[N-1 -: M] ^ SIGN_MASK;
    assign step  = step_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_lfsr_noise_gen.sv
// Bench for lfsr_noise_gen: directed steps plus random traffic against an arithmetic model;
// a second SIGNED=1 instance shares all stimulus.
module tb_lfsr_noise_gen;

    localparam int TAPS_I = 'h3802;

    logic        clk = 1'b0;
    logic        rst, en, seed_load;
    logic [7:0]  div;
    logic [13:0] seed;
    logic [11:0] noise, noise_s;
    logic        step, wrap, step_s, wrap_s;

    lfsr_noise_gen dut (
        .clk(clk), .rst(rst), .en(en), .div(div), .seed_load(seed_load), .seed(seed),
        .noise(noise), .step(step), .wrap(wrap)
    );

    lfsr_noise_gen #(.SIGNED(1'b1)) dut_s (
        .clk(clk), .rst(rst), .en(en), .div(div), .seed_load(seed_load), .seed(seed),
        .noise(noise_s), .step(step_s), .wrap(wrap_s)
    );

    always #5 clk = ~clk;

    int ntotal = 0;
    int npass  = 0;

    // Reference state, kept as plain integers
    int m_shift, m_seed, m_cnt, m_step, m_wrap;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int lfsr_next(input int s);
        int ones = 0;
        for (int i = 0; i < 14; i++)
            if (((TAPS_I >> i) & 1) != 0 && ((s >> i) & 1) != 0) ones++;
        return ((s * 2) % 16384) + ((ones % 2 == 0) ? 1 : 0);
    endfunction

    // Advance the model from current inputs, clock once, compare all outputs.
    task automatic tick();
        if (rst) begin
            m_shift = 0; m_seed = 0; m_cnt = 0; m_step = 0; m_wrap = 0;
        end else if (seed_load) begin
            m_shift = (int'(seed) == 16383) ? 0 : int'(seed);
            m_seed  = m_shift; m_cnt = 0; m_step = 0; m_wrap = 0;
        end else if (en) begin
            if (m_cnt >= int'(div)) begin
                m_shift = (m_shift == 16383) ? m_seed : lfsr_next(m_shift);
                m_step  = 1;
                m_wrap  = (m_shift == m_seed) ? 1 : 0;
                m_cnt   = 0;
            end else begin
                m_cnt++; m_step = 0; m_wrap = 0;
            end
        end else begin
            m_step = 0; m_wrap = 0;
        end
        @(posedge clk);
        #1;
        check("noise",   32'(noise),   32'(m_shift / 4));
        check("noise_s", 32'(noise_s), 32'((m_shift / 4) ^ 2048));
        check("step",    32'(step),    32'(m_step));
        check("wrap",    32'(wrap),    32'(m_wrap));
    endtask

    int wraps, wrap_idx, wrap_noise;

    initial begin
        rst = 1'b1; en = 1'b0; seed_load = 1'b0; div = 8'd0; seed = 14'd0;
        m_shift = 0; m_seed = 0; m_cnt = 0; m_step = 0; m_wrap = 0;
        tick(); tick();
        check("rst_noise",   32'(noise),   32'h000);
        check("rst_noise_s", 32'(noise_s), 32'h800);
        check("rst_step",    32'(step),    32'd0);

        // Free-running from reset: 0 -> 1 -> 3 -> 6
        rst = 1'b0; en = 1'b1; div = 8'd0;
        tick(); check("t1_n1", 32'(noise), 32'd0); check("t1_s1", 32'(step), 32'd1);
        tick(); check("t1_n2", 32'(noise), 32'd0); check("t1_s2", 32'(step), 32'd1);
        tick(); check("t1_n3", 32'(noise), 32'd1); check("t1_s3", 32'(step), 32'd1);

        // div=3: steps on enabled cycles 4, 8, 12; en gap of 5 mid-count
        rst = 1'b1; tick(); rst = 1'b0; div = 8'd3;
        for (int k = 1; k <= 12; k++) begin
            if (k == 7) begin
                en = 1'b0;
                for (int g = 0; g < 5; g++) begin
                    tick(); check("t2_gap_step", 32'(step), 32'd0);
                end
            end
            en = 1'b1;
            tick();
            check("t2_step", 32'(step), 32'((k % 4 == 0) ? 1 : 0));
        end

        // Random traffic
        for (int r = 0; r < 400; r++) begin
            en        = ($urandom_range(0, 3) != 0);
            div       = 8'($urandom_range(0, 3));
            seed_load = ($urandom_range(0, 19) == 0);
            seed      = ($urandom_range(0, 4) == 0) ? 14'h3FFF : 14'($urandom);
            rst       = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0; seed_load = 1'b0;

        // Seed load with en high: no step; then a full period wraps exactly once
        en = 1'b1; div = 8'd0; seed_load = 1'b1; seed = 14'h1234;
        tick();
        check("t3_load_noise", 32'(noise), 32'h48D);
        check("t3_load_step",  32'(step),  32'd0);
        seed_load = 1'b0;
        wraps = 0; wrap_idx = -1; wrap_noise = -1;
        for (int i = 1; i <= 16383; i++) begin
            tick();
            if (wrap) begin wraps++; wrap_idx = i; wrap_noise = int'(noise); end
        end
        check("t3_wraps",      32'(wraps),      32'd1);
        check("t3_wrap_idx",   32'(wrap_idx),   32'd16383);
        check("t3_wrap_noise", 32'(wrap_noise), 32'h48D);

        // All-ones seed falls back to SEED
        seed_load = 1'b1; seed = 14'h3FFF;
        tick();
        check("t4_ones_noise", 32'(noise), 32'd0);
        seed = 14'h0155; en = 1'b0;
        tick();
        seed_load = 1'b0;
        // Lock-up guard: plant all-ones, next step reloads seed_reg
        force dut.shift_q = 14'h3FFF;
        #1;
        release dut.shift_q;
        force dut_s.shift_q = 14'h3FFF;
        #1;
        release dut_s.shift_q;
        m_shift = 16383;
        check("t4_forced", 32'(noise), 32'hFFF);
        en = 1'b1; div = 8'd0;
        tick();
        check("t4_guard_noise", 32'(noise), 32'h055);
        check("t4_guard_step",  32'(step),  32'd1);
        check("t4_guard_wrap",  32'(wrap),  32'd1);

        // div lowered 200 -> 2 at cnt=50
        rst = 1'b1; tick(); rst = 1'b0;
        en = 1'b1; div = 8'd200;
        for (int i = 0; i < 50; i++) tick();
        div = 8'd2;
        tick(); check("t5_first", 32'(step), 32'd1);
        for (int i = 1; i <= 9; i++) begin
            tick(); check("t5_period", 32'(step), 32'((i % 3 == 0) ? 1 : 0));
        end

        // Reset during an active sequence
        rst = 1'b1; tick();
        check("t6_rst_noise",   32'(noise),   32'h000);
        check("t6_rst_noise_s", 32'(noise_s), 32'h800);
        check("t6_rst_step",    32'(step),    32'd0);
        rst = 1'b0;
        tick(); check("t6_after_noise", 32'(noise), 32'd0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
